soc_boot_sequencer: RTL

// Power-up and recovery sequencer between the board clock/reset and the SoC clock wrapper.
// It resets the MMCM and qualifies its lock, then releases the peripheral and core resets in order.

---
 rtl/soc_boot_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/soc_boot_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/soc_boot_pkg.sv
// soc_boot_pkg: shared state encoding and helpers for the SoC boot sequencer.
package soc_boot_pkg;

    typedef enum logic [2:0] {
        MMCM_RST   = 3'd0,
        WAIT_LOCK  = 3'd1,
        PERIPH_REL = 3'd2,
        CORE_REL   = 3'd3,
        RUN        = 3'd4
    } boot_state_t;

    localparam int RETRY_W = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic is_released(input boot_state_t s);
        return s inside {PERIPH_REL, CORE_REL, RUN};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/soc_boot_sequencer.sv
// soc_boot_sequencer: resets and qualifies the MMCM, then releases periph, core and fetch in order,
// recovering from lock loss and debug soft resets.
module soc_boot_sequencer
    import soc_boot_pkg::*;
#(
    parameter int MMCM_RST_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES = 64,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int PERIPH_DELAY       = 32,
    parameter int CORE_DELAY         = 32,
    parameter int MAX_RETRIES        = 7
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               mmcm_locked,
    input  logic               soft_reset_req,
    output logic               mmcm_reset,
    output logic               periph_reset_n,
    output logic               core_reset_n,
    output logic               fetch_enable,
    output logic               boot_done,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state_o
);

    localparam int MAX_P  = max_int(max_int(max_int(MMCM_RST_CYCLES, LOCK_STABLE_CYCLES),
                                            max_int(LOCK_TIMEOUT, PERIPH_DELAY)), CORE_DELAY);
    localparam int CNT_W  = $clog2(MAX_P) + 1;
    localparam int STAB_W = $clog2(LOCK_STABLE_CYCLES) + 1;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(MMCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   PERIPH_LAST = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0]   CORE_LAST   = CNT_W'(CORE_DELAY - 1);
    localparam logic [STAB_W-1:0]  STAB_LAST   = STAB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    boot_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               locked_s;
    logic               hold_q;
    logic               lock_loss, soft_rel, timeout;
    logic               mmcm_reset_q, mmcm_reset_d;
    logic               periph_q, periph_d;
    logic               core_q, core_d;
    logic               run_q, run_d;
    logic               lost_q, lost_d;

    sync_2ff u_lock_sync (
        .clk (clk_100MHz),
        .rst (reset),
        .d_i (mmcm_locked),
        .q_o (locked_s)
    );

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q      <= MMCM_RST;
            hold_q       <= 1'b0;
            mmcm_reset_q <= 1'b1;
            periph_q     <= 1'b0;
            core_q       <= 1'b0;
            run_q        <= 1'b0;
            lost_q       <= 1'b0;
            retry_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= soft_rel;
            mmcm_reset_q <= mmcm_reset_d;
            periph_q     <= periph_d;
            core_q       <= core_d;
            run_q        <= run_d;
            lost_q       <= lost_d;
            retry_q      <= retry_d;
        end
    end

    // Lock loss outranks soft reset, which outranks the release timers.
    always_comb begin
        state_d   = state_q;
        lock_loss = 1'b0;
        soft_rel  = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            MMCM_RST: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (locked_s && stab_q == STAB_LAST) begin
                    state_d = PERIPH_REL;
                end else if (cnt_q == TO_LAST) begin
                    state_d = MMCM_RST;
                    timeout = 1'b1;
                end
            end
            PERIPH_REL, CORE_REL, RUN: begin
                if (!locked_s) begin
                    state_d   = MMCM_RST;
                    lock_loss = 1'b1;
                end else if (soft_reset_req) begin
                    state_d  = PERIPH_REL;
                    soft_rel = 1'b1;
                end else if (state_q == PERIPH_REL && !hold_q && cnt_q == PERIPH_LAST) begin
                    state_d = CORE_REL;
                end else if (state_q == CORE_REL && cnt_q == CORE_LAST) begin
                    state_d = RUN;
                end
            end
            default: state_d = MMCM_RST;
        endcase
    end

    // A soft reset holds periph in reset for one cycle before PERIPH_REL timing restarts.
    always_comb begin
        mmcm_reset_d = state_d == MMCM_RST;
        periph_d     = is_released(state_d) && !soft_rel;
        core_d       = state_d == CORE_REL || state_d == RUN;
        run_d        = state_d == RUN;
        lost_d       = lost_q || lock_loss;
        retry_d      = (timeout && retry_q != RETRY_MAX) ? retry_q + 1'b1 : retry_q;
    end

    assign cnt_d  = (state_d != state_q || soft_rel || hold_q || state_q == RUN) ? '0 : cnt_q + 1'b1;
    assign stab_d = (state_q == WAIT_LOCK && locked_s) ? stab_q + 1'b1 : '0;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            cnt_q  <= '0;
            stab_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            stab_q <= stab_d;
        end
    end

    assign mmcm_reset     = mmcm_reset_q;
    assign periph_reset_n = periph_q;
    assign core_reset_n   = core_q;
    assign fetch_enable   = run_q;
    assign boot_done      = run_q;
    assign lock_lost      = lost_q;
    assign retry_cnt      = retry_q;
    assign state_o        = state_q;

endmodule
